// File: rtl/dmem_if.sv
// Data-memory port between the processor (master) and the memory-side responder (slave).
interface dmem_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q_dmem;
  logic                  mmio_hit;

  modport master (
    output address_dmem, data, wren,
    input  q_dmem, mmio_hit
  );

  modport slave (
    input  address_dmem, data, wren,
    output q_dmem, mmio_hit
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port RAM with one-cycle read latency plus a top-of-space
// register window (LED, free-running cycle counter, RAM-store counter).
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MMIO_WORDS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_if.slave                 bus,
  output logic [DATA_WIDTH-1:0] led_out
);
  localparam int unsigned RAM_DEPTH = (1 << ADDR_WIDTH) - MMIO_WORDS;
  localparam int unsigned OFF_W     = $clog2(MMIO_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MMIO_BASE = ADDR_WIDTH'(RAM_DEPTH);
  localparam logic [OFF_W-1:0] OFF_LED    = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_CYCLE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_STORES = OFF_W'(2);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] led_q, led_d;
  logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
  logic [DATA_WIDTH-1:0] stores_q, stores_d;
  logic                  hit_q;

  logic                  is_mmio_c;
  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_idx_c;
  logic [OFF_W-1:0]      offset_c;
  logic [DATA_WIDTH-1:0] ram_rd_c;
  logic [DATA_WIDTH-1:0] mmio_rd_c;

  // Address decode; RAM index is parked at 0 for window addresses so it never exceeds the array.
  always_comb begin
    is_mmio_c = (bus.address_dmem >= MMIO_BASE);
    offset_c  = OFF_W'(bus.address_dmem - MMIO_BASE);
    ram_idx_c = is_mmio_c ? '0 : bus.address_dmem;
    ram_we_c  = bus.wren && !is_mmio_c && !reset;
    ram_rd_c  = mem[ram_idx_c];
  end

  // RAM storage has no reset; the read path captures the pre-write word into q_q.
  always_ff @(posedge clock) begin
    if (ram_we_c) begin
      mem[ram_idx_c] <= bus.data;
    end
  end

  // Register window: reads return pre-edge values, writes override the default updates.
  always_comb begin
    led_d     = led_q;
    cycle_d   = cycle_q + DATA_WIDTH'(1);
    stores_d  = stores_q + DATA_WIDTH'(ram_we_c);
    mmio_rd_c = '0;
    if (is_mmio_c) begin
      case (offset_c)
        OFF_LED: begin
          mmio_rd_c = led_q;
          if (bus.wren) led_d = bus.data;
        end
        OFF_CYCLE: begin
          mmio_rd_c = cycle_q;
          if (bus.wren) cycle_d = bus.data;
        end
        OFF_STORES: begin
          mmio_rd_c = stores_q;
          if (bus.wren) stores_d = '0;
        end
        default: mmio_rd_c = '0;
      endcase
    end
    q_d = is_mmio_c ? mmio_rd_c : ram_rd_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q      <= '0;
      led_q    <= '0;
      cycle_q  <= '0;
      stores_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      hit_q    <= is_mmio_c;
    end
  end

  assign bus.q_dmem   = q_q;
  assign bus.mmio_hit = hit_q;
  assign led_out      = led_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-level memory/register model.
module tb_dmem_responder;
  logic        clock;
  logic        reset;
  logic        clk_en;
  logic [31:0] led_out;
  int          total;
  int          bad;

  dmem_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  dmem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MMIO_WORDS(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .led_out(led_out)
  );

  initial begin
    clock = 1'b0;
    wait (clk_en);
    forever #5 clock = ~clock;
  end

  // Reference model: plain word array plus the three registers.
  logic [31:0] m_ram [0:4095];
  logic [31:0] m_led, m_cycle, m_stores;

  // One access per clock edge: predicts the read result, advances the model, then samples #1 after the edge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input bit w,
                      output logic [31:0] eq, output bit eh);
    int off;
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    eh  = (a >= 12'hFF0);
    off = int'(a) - 32'hFF0;
    if (eh) eq = (off == 0) ? m_led : (off == 1) ? m_cycle : (off == 2) ? m_stores : 32'd0;
    else    eq = m_ram[a];
    m_cycle = m_cycle + 32'd1;
    if (w) begin
      if (!eh) begin
        m_ram[a] = d;
        m_stores = m_stores + 32'd1;
      end else if (off == 0) m_led = d;
      else if (off == 1) m_cycle = d;
      else if (off == 2) m_stores = 32'd0;
    end
    @(posedge clock);
    #1;
    bus.wren = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] eq;
    bit eh;
    #5 reset = 1'b1;
    #1;
    total++; if (bus.q_dmem !== 32'd0) begin bad++; $display("FAIL reset_q got=%h want=0", bus.q_dmem); end
    total++; if (led_out !== 32'd0) begin bad++; $display("FAIL reset_led got=%h want=0", led_out); end
    total++; if (bus.mmio_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", bus.mmio_hit); end
    m_led = 0; m_cycle = 0; m_stores = 0;
    clk_en = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(12'hFF1, 32'd0, 1'b0, eq, eh);
      total++;
      if (bus.q_dmem !== 32'(i) || eq !== 32'(i)) begin
        bad++; $display("FAIL reset_cycle%0d got=%h want=%h", i, bus.q_dmem, 32'(i));
      end
    end
  endtask

  task automatic test_ram_roundtrip;
    logic [31:0] eq;
    bit eh;
    step(12'h010, 32'hDEADBEEF, 1'b1, eq, eh);
    step(12'h010, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_read got=%h want=deadbeef", bus.q_dmem); end
    total++; if (bus.mmio_hit !== 1'b0) begin bad++; $display("FAIL ram_hit got=%b want=0", bus.mmio_hit); end
    step(12'h010, 32'h1, 1'b1, eq, eh);
    total++; if (bus.q_dmem !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_rdw got=%h want=deadbeef", bus.q_dmem); end
    step(12'h010, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'h1) begin bad++; $display("FAIL ram_new got=%h want=1", bus.q_dmem); end
  endtask

  task automatic test_led;
    logic [31:0] eq;
    bit eh;
    step(12'hFF0, 32'h0000_00A5, 1'b1, eq, eh);
    total++; if (led_out !== 32'hA5) begin bad++; $display("FAIL led_write got=%h want=a5", led_out); end
    step(12'hFF0, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'hA5) begin bad++; $display("FAIL led_read got=%h want=a5", bus.q_dmem); end
    total++; if (bus.mmio_hit !== 1'b1) begin bad++; $display("FAIL led_hit got=%b want=1", bus.mmio_hit); end
    step(12'hFF5, 32'h1234, 1'b1, eq, eh);
    step(12'hFF5, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'd0) begin bad++; $display("FAIL unused_read got=%h want=0", bus.q_dmem); end
    total++; if (led_out !== 32'hA5) begin bad++; $display("FAIL led_kept got=%h want=a5", led_out); end
  endtask

  task automatic test_stores;
    logic [31:0] eq;
    bit eh;
    step(12'hFF2, 32'h55, 1'b1, eq, eh);
    for (int i = 0; i < 3; i++) step(12'h020 + 12'(i), $urandom, 1'b1, eq, eh);
    step(12'hFF0, 32'hA5, 1'b1, eq, eh);
    step(12'hFF2, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'd3) begin bad++; $display("FAIL stores_count got=%h want=3", bus.q_dmem); end
    step(12'hFF2, 32'hFFFF, 1'b1, eq, eh);
    step(12'hFF2, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'd0) begin bad++; $display("FAIL stores_clear got=%h want=0", bus.q_dmem); end
  endtask

  task automatic test_wrap;
    logic [31:0] eq;
    bit eh;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0;
    step(12'hFF1, 32'hFFFF_FFFE, 1'b1, eq, eh);
    for (int i = 0; i < 3; i++) begin
      step(12'hFF1, 32'd0, 1'b0, eq, eh);
      total++;
      if (bus.q_dmem !== want[i]) begin bad++; $display("FAIL wrap%0d got=%h want=%h", i, bus.q_dmem, want[i]); end
    end
  endtask

  task automatic test_random;
    logic [31:0] eq;
    bit eh;
    logic [11:0] addrs [8];
    logic [11:0] a;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 12'($urandom_range(32'h100, 32'hFEF));
      step(addrs[i], $urandom, 1'b1, eq, eh);
    end
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 0) a = addrs[$urandom_range(0, 7)];
      else a = 12'hFF0 + 12'($urandom_range(0, 15));
      step(a, $urandom, ($urandom_range(0, 2) == 0), eq, eh);
      total++;
      if (bus.q_dmem !== eq || bus.mmio_hit !== eh || led_out !== m_led) begin
        bad++;
        $display("FAIL rand%0d addr=%h got q=%h hit=%b led=%h want q=%h hit=%b led=%h",
                 n, a, bus.q_dmem, bus.mmio_hit, led_out, eq, eh, m_led);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] eq;
    bit eh;
    step(12'h010, 32'hDEADBEEF, 1'b1, eq, eh);
    step(12'hFF0, 32'hA5, 1'b1, eq, eh);
    step(12'hFF1, 32'd96, 1'b1, eq, eh);
    step(12'hFF0, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'hA5) begin bad++; $display("FAIL pre_reset got=%h want=a5", bus.q_dmem); end
    #1 reset = 1'b1;
    #1;
    total++; if (led_out !== 32'd0 || bus.q_dmem !== 32'd0) begin
      bad++; $display("FAIL async_reset got led=%h q=%h want 0/0", led_out, bus.q_dmem);
    end
    reset = 1'b0;
    m_led = 0; m_cycle = 0; m_stores = 0;
    step(12'h010, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_kept got=%h want=deadbeef", bus.q_dmem); end
    step(12'hFF1, 32'd0, 1'b0, eq, eh);
    total++; if (bus.q_dmem !== 32'd1) begin bad++; $display("FAIL cycle_after got=%h want=1", bus.q_dmem); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk_en = 1'b0;
    reset  = 1'b0;
    bus.address_dmem = '0;
    bus.data = '0;
    bus.wren = 1'b0;
    test_reset();
    test_ram_roundtrip();
    test_led();
    test_stores();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
